// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised single-clock UART transmitter.
//   Baud timing comes from a clock-enable divider on clkIN, DIV = round(CLK_FREQ / BAUD_RATE).
//   Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits(1).
//   Optional feature macro: UART_TX_FIFO_EN adds a FIFO_DEPTH-entry transmit FIFO;
//   without it a single word is latched into the shifter on accept.
// Ports:
//   clkIN        system clock
//   nResetIN     asynchronous active-low reset
//   dataIN       word to send, latched on accept
//   sendIN       send request; accepted on a clkIN edge where nBusyOUT=1
//   txOUT        serial line, idle high (registered)
//   nBusyOUT     1 = ready to accept a word (registered)
//   frameDoneOUT one-cycle pulse during the last clock of the final stop bit (registered)
module uart_tx_param #(
    parameter int unsigned CLK_FREQ   = 48_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clkIN,
    input  logic                 nResetIN,
    input  logic [DATA_BITS-1:0] dataIN,
    input  logic                 sendIN,
    output logic                 txOUT,
    output logic                 nBusyOUT,
    output logic                 frameDoneOUT
);

    localparam int unsigned DIV   = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned BIT_W = 4;

    // Elaboration-time parameter checks
    if (DIV < 2) begin : gBadDiv
        $error("uart_tx_param: DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : gBadParity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadFifoDepth
        $error("uart_tx_param: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } stateT;

    stateT                state, stateNext;
    logic [CNT_W-1:0]     baudCnt, baudNext;
    logic [BIT_W-1:0]     bitCnt, bitNext;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parityReg;
    logic                 txNext, doneNext, nBusyNext;
    logic                 bitEnd, load, pending, accept;
    logic [DATA_BITS-1:0] loadData;

    assign accept = sendIN && nBusyOUT;
    assign bitEnd = (baudCnt == CNT_W'(DIV - 1));

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr, rdPtr;
    logic [FCNT_W-1:0]    fifoCount, countNext;

    assign pending   = (fifoCount != '0);
    assign loadData  = fifoMem[rdPtr];
    assign countNext = fifoCount + FCNT_W'(accept) - FCNT_W'(load);
    assign nBusyNext = (countNext != FCNT_W'(FIFO_DEPTH));

    // FIFO storage; contents need no reset, pointers define emptiness
    always_ff @(posedge clkIN) begin
        if (accept) begin
            fifoMem[wrPtr] <= dataIN;
        end
    end

    // FIFO pointers and occupancy; write on accept, pop when the FSM loads a word
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (accept) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (load) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            fifoCount <= countNext;
        end
    end
`else
    // Word goes straight into the shifter; ready again only once back in IDLE
    assign pending   = accept;
    assign loadData  = dataIN;
    assign nBusyNext = !accept && (state == S_IDLE);
`endif

    // State and counter registers
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state   <= S_IDLE;
            baudCnt <= '0;
            bitCnt  <= '0;
        end else begin
            state   <= stateNext;
            baudCnt <= baudNext;
            bitCnt  <= bitNext;
        end
    end

    // Next-state, counters and line level; txOUT follows the current state one clock later
    always_comb begin
        stateNext = state;
        baudNext  = baudCnt + CNT_W'(1);
        bitNext   = bitCnt;
        txNext    = 1'b1;
        doneNext  = 1'b0;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                baudNext = '0;
                if (pending) begin
                    stateNext = S_START;
                    bitNext   = '0;
                    load      = 1'b1;
                end
            end
            S_START: begin
                txNext = 1'b0;
                if (bitEnd) begin
                    stateNext = S_DATA;
                    baudNext  = '0;
                    bitNext   = '0;
                end
            end
            S_DATA: begin
                txNext = shiftReg[0];
                if (bitEnd) begin
                    baudNext = '0;
                    if (bitCnt == BIT_W'(DATA_BITS - 1)) begin
                        bitNext   = '0;
                        stateNext = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bitNext = bitCnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                txNext = parityReg;
                if (bitEnd) begin
                    stateNext = S_STOP;
                    baudNext  = '0;
                    bitNext   = '0;
                end
            end
            S_STOP: begin
                txNext = 1'b1;
                if (bitEnd) begin
                    baudNext = '0;
                    if (bitCnt == BIT_W'(STOP_BITS - 1)) begin
                        doneNext = 1'b1;
                        bitNext  = '0;
                        // Pending word starts on the very next clock: no idle gap
                        if (pending) begin
                            stateNext = S_START;
                            load      = 1'b1;
                        end else begin
                            stateNext = S_IDLE;
                        end
                    end else begin
                        bitNext = bitCnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                stateNext = S_IDLE;
                baudNext  = '0;
                bitNext   = '0;
            end
        endcase
    end

    // Shifter and parity latched at load; parity sized so total ones match the mode
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            shiftReg  <= '0;
            parityReg <= 1'b0;
        end else if (load) begin
            shiftReg  <= loadData;
            parityReg <= (PARITY == 1) ? ~^loadData : ^loadData;
        end else if (state == S_DATA && bitEnd) begin
            shiftReg <= shiftReg >> 1;
        end
    end

    // Registered outputs
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            txOUT        <= 1'b1;
            nBusyOUT     <= 1'b1;
            frameDoneOUT <= 1'b0;
        end else begin
            txOUT        <= txNext;
            nBusyOUT     <= nBusyNext;
            frameDoneOUT <= doneNext;
        end
    end

endmodule
